// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: collects intermediate FP results from the misc, madd and
// div/sqrt units, grants one source per cycle and queues the granted result
// in a 2-entry FIFO ahead of the shared normalize/round stage. The FIFO head
// is registered, which keeps the unit result muxes off the normalize/round
// timing path.
//
// Optional build macro FP_WB_ARB_RR_EN: replaces the fixed-priority grant
// (highest index wins) with a round-robin grant. A registered last-grant
// index gives the most recently granted source the lowest priority.
//
// Round-robin scan order: the search starts at the index just below the
// last grant and walks downward, wrapping at zero. The last grant resets to
// NUM_SOURCES-1, which places div/sqrt at the bottom of the order until
// some other source has been granted.

module fp_wb_arbiter #(
    parameter int NUM_SOURCES = 3,
    parameter int ID_W        = 2,
    parameter int DATA_W      = 96
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SOURCES-1:0]        src_done,
    input  logic [NUM_SOURCES*ID_W-1:0]   src_id,
    input  logic [NUM_SOURCES*DATA_W-1:0] src_data,
    output logic [NUM_SOURCES-1:0]        src_ack,
    output logic                          out_valid,
    output logic [ID_W-1:0]               out_id,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready
);

    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [ID_W-1:0]        fifo_id   [2];
    logic [DATA_W-1:0]      fifo_data [2];
    logic [1:0]             count;
    logic                   wr_ptr;
    logic                   rd_ptr;

    logic                   push_en;
    logic                   push;
    logic                   pop;
    logic [NUM_SOURCES-1:0] grant;
    logic [ID_W-1:0]        sel_id;
    logic [DATA_W-1:0]      sel_data;

    // out_ready is left out on purpose: no combinational path to src_ack.
    // A full FIFO therefore drains one entry before the next push.
    assign push_en = (count != 2'd2) && !rst;
    assign src_ack = push_en ? grant : '0;
    assign push    = |src_ack;
    assign pop     = out_valid && out_ready;

`ifdef FP_WB_ARB_RR_EN

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;

    // Round-robin grant: scan downward starting just below the last grant.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            idx = (int'(last_grant) + NUM_SOURCES - k) % NUM_SOURCES;
            if (!found && src_done[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Encode the one-hot grant for the last-grant register.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Last-grant index moves only when a grant is actually acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_SOURCES - 1);
        end else if (push) begin
            last_grant <= grant_idx;
        end
    end

`else

    // Fixed priority: the highest requesting index wins (div/sqrt on top).
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (src_done[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

`endif

    // Route the acknowledged source's id and payload to the FIFO write port.
    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (src_ack[i]) begin
                sel_id   = src_id[i*ID_W +: ID_W];
                sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Occupancy and pointers; a push and pop in the same cycle keep count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage, cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_id[0]   <= '0;
            fifo_id[1]   <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else if (push) begin
            fifo_id[wr_ptr]   <= sel_id;
            fifo_data[wr_ptr] <= sel_data;
        end
    end

    // Head of the FIFO drives the outputs directly from registers.
    always_comb begin
        out_valid = (count != 2'd0);
        out_id    = fifo_id[rd_ptr];
        out_data  = fifo_data[rd_ptr];
    end

`ifndef SYNTHESIS
    a_ack_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(src_ack))
        else $error("fp_wb_arbiter: src_ack not onehot0 (%b)", src_ack);
    a_count_max : assert property (@(posedge clk) disable iff (rst) count <= 2'd2)
        else $error("fp_wb_arbiter: count above 2 (%0d)", count);
    a_no_empty_pop : assert property (@(posedge clk) disable iff (rst) !(pop && count == 2'd0))
        else $error("fp_wb_arbiter: pop while empty");
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Testbench for fp_wb_arbiter (default fixed-priority build). A queue-based
// reference model tracks what should be in the FIFO; sources hold their
// result until acknowledged and then drop or replace it.

module tb_fp_wb_arbiter;

    localparam int NS = 3;
    localparam int IW = 2;
    localparam int DW = 96;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } ent_t;

    logic              clk;
    logic              rst;
    logic [NS-1:0]     src_done;
    logic [NS*IW-1:0]  src_id;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_ack;
    logic              out_valid;
    logic [IW-1:0]     out_id;
    logic [DW-1:0]     out_data;
    logic              out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    ent_t q[$];

    fp_wb_arbiter #(.NUM_SOURCES(NS), .ID_W(IW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_done  (src_done),
        .src_id    (src_id),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Expected grant: nothing while full or in reset, else highest requester.
    function automatic logic [NS-1:0] model_ack();
        logic [NS-1:0] r;
        r = '0;
        if (rst || q.size() >= 2) return r;
        for (int i = NS - 1; i >= 0; i--) begin
            if (src_done[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic set_src(input int i, input logic [IW-1:0] id, input logic [DW-1:0] d);
        src_done[i]          = 1'b1;
        src_id[i*IW +: IW]   = id;
        src_data[i*DW +: DW] = d;
    endtask

    // Advance one clock, applying the reference rules to the model queue.
    // An acknowledged source pops its result (done drops) just after the edge.
    task automatic clock_model();
        logic [NS-1:0] a;
        bit            do_pop;
        ent_t          e;
        a      = model_ack();
        do_pop = (q.size() > 0) && out_ready;
        e.id   = '0;
        e.data = '0;
        for (int i = 0; i < NS; i++) begin
            if (a[i]) begin
                e.id   = src_id[i*IW +: IW];
                e.data = src_data[i*DW +: DW];
            end
        end
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (a != '0) begin
            q.push_back(e);
            for (int i = 0; i < NS; i++) if (a[i]) src_done[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; src_done = '1; src_id = '1; src_data = '1; out_ready = 1'b1;
        q.delete();
        #12;
        n_tests++;
        if (src_ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b want 000", src_ack); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++;
        if (out_id !== 2'd0 || out_data !== 96'd0) begin
            n_fail++; $display("FAIL reset_head: got id %0h data %0h want 0", out_id, out_data);
        end
        @(negedge clk);
        rst = 1'b0; src_done = '0; src_id = '0; src_data = '0; out_ready = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_src(0, 2'd1, 96'hA5); out_ready = 1'b1;
        #1;
        n_tests++;
        if (src_ack !== 3'b001) begin n_fail++; $display("FAIL single_ack: got %b want 001", src_ack); end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 96'hA5) begin
            n_fail++;
            $display("FAIL single_out: got v%b id%0d d%0h want v1 id1 dA5", out_valid, out_id, out_data);
        end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_tie();
        @(negedge clk);
        set_src(2, 2'd2, rand_data()); set_src(0, 2'd0, rand_data()); out_ready = 1'b1;
        #1;
        n_tests++;
        if (src_ack !== 3'b100) begin n_fail++; $display("FAIL tie_first: got %b want 100", src_ack); end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (src_ack !== 3'b001) begin n_fail++; $display("FAIL tie_second: got %b want 001", src_ack); end
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) begin
            n_fail++; $display("FAIL tie_out1: got v%b id%0d want v1 id2", out_valid, out_id);
        end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== q[0].data) begin
            n_fail++; $display("FAIL tie_out2: got v%b id%0d want v1 id0", out_valid, out_id);
        end
        clock_model();
    endtask

    task automatic test_full();
        @(negedge clk);
        out_ready = 1'b0;
        set_src(0, 2'd1, rand_data()); set_src(1, 2'd2, rand_data()); set_src(2, 2'd3, rand_data());
        #1;
        n_tests++;
        if (src_ack !== 3'b100) begin n_fail++; $display("FAIL full_ack0: got %b want 100", src_ack); end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (src_ack !== 3'b010) begin n_fail++; $display("FAIL full_ack1: got %b want 010", src_ack); end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (src_ack !== 3'b000 || q.size() != 2) begin
            n_fail++; $display("FAIL full_hold: got %b want 000 (model depth %0d)", src_ack, q.size());
        end
        clock_model();
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (src_ack !== 3'b000) begin n_fail++; $display("FAIL full_ready_noack: got %b want 000", src_ack); end
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd3) begin
            n_fail++; $display("FAIL full_head: got v%b id%0d want v1 id3", out_valid, out_id);
        end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (src_ack !== 3'b001) begin n_fail++; $display("FAIL full_after_pop: got %b want 001", src_ack); end
        n_tests++;
        if (out_id !== 2'd2) begin n_fail++; $display("FAIL full_order: got id%0d want id2", out_id); end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            n_fail++; $display("FAIL full_last: got v%b id%0d want v1 id1", out_valid, out_id);
        end
        clock_model();
    endtask

    task automatic test_steady();
        @(negedge clk);
        out_ready = 1'b0;
        set_src(1, 2'd0, rand_data());
        clock_model();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            set_src(1, IW'(c + 1), rand_data());
            #1;
            n_tests++;
            if (src_ack !== 3'b010 || out_valid !== 1'b1 || out_id !== q[0].id || q.size() != 1) begin
                n_fail++;
                $display("FAIL steady_%0d: got ack%b v%b id%0d want ack010 v1 id%0d", c, src_ack, out_valid, out_id, q[0].id);
            end
            clock_model();
        end
        @(negedge clk);
        src_done = '0;
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL steady_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if (!src_done[i] && ($urandom % 3 == 0)) set_src(i, IW'($urandom), rand_data());
            end
            out_ready = ($urandom % 4) != 0;
            #1;
            n_tests++;
            if (src_ack !== model_ack() || out_valid !== (q.size() != 0) ||
                (q.size() != 0 && (out_id !== q[0].id || out_data !== q[0].data))) begin
                n_fail++;
                if (bad < 5)
                    $display("FAIL random_%0d: got ack%b v%b id%0d want ack%b v%b", c, src_ack, out_valid, out_id, model_ack(), q.size() != 0);
                bad++;
            end
            clock_model();
        end
        @(negedge clk);
        src_done = '0; out_ready = 1'b1;
        repeat (3) clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            n_fail++; $display("FAIL random_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        set_src(0, 2'd1, rand_data()); set_src(1, 2'd2, rand_data());
        clock_model();
        clock_model();
        @(negedge clk);
        set_src(0, 2'd1, rand_data()); set_src(1, 2'd2, rand_data()); set_src(2, 2'd3, rand_data());
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || q.size() != 2) begin
            n_fail++; $display("FAIL arst_pre: got %b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || src_ack !== 3'b000) begin
            n_fail++; $display("FAIL arst_immediate: got v%b ack%b want v0 ack000", out_valid, src_ack);
        end
        @(negedge clk);
        rst = 1'b0; src_done = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_release: got %b want 0", out_valid); end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_idle: got %b want 0", out_valid); end
        @(negedge clk);
        set_src(2, 2'd3, 96'h1234); out_ready = 1'b1;
        #1;
        n_tests++;
        if (src_ack !== 3'b100) begin n_fail++; $display("FAIL arst_newack: got %b want 100", src_ack); end
        clock_model();
        @(negedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 96'h1234) begin
            n_fail++; $display("FAIL arst_newout: got v%b id%0d d%0h want v1 id3 d1234", out_valid, out_id, out_data);
        end
        clock_model();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_full();
        test_steady();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Downstream consumer of the FP intermediate writeback ports: collects results from the div/sqrt, madd and misc FP units.
- Selects one result per cycle and acknowledges its source.
- Buffers the selected result in a 2-entry FIFO that feeds the shared FP normalization/rounding stage.
- Registering the FIFO output breaks the long combinational path from the unit muxes into normalize/round.

Parameters:
- NUM_SOURCES, 3, number of intermediate writeback sources. Index NUM_SOURCES-1 is the longest-latency unit, div/sqrt.
- ID_W, 2, width of the instruction id.
- DATA_W, 96, width of the packed remaining intermediate fields. Fields are rd, expo_overflow, fflags, rm, carry, safe, hidden, grs, clz, right_shift, right_shift_amt, subnormal, ignore_max_expo, d2s.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- src_done  input  NUM_SOURCES  per-source result valid
- src_id  input  NUM_SOURCES*ID_W  per-source id; source i occupies slice [i*ID_W +: ID_W]
- src_data  input  NUM_SOURCES*DATA_W  per-source packed payload; same slicing as src_id
- src_ack  output  NUM_SOURCES  one-hot acknowledge; the source pops its result on ack
- out_valid  output  1  FIFO head valid toward normalize/round
- out_id  output  ID_W  head id
- out_data  output  DATA_W  head payload
- out_ready  input  1  downstream accepts the head this cycle

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: out_valid=0, out_id=0, out_data=0, src_ack=0. FIFO count, read pointer and write pointer all 0.
- Reset mid-operation: all buffered entries are discarded. No ack is asserted during rst.
- Push enable: push_en = (count<2). Deliberately excludes out_ready, so there is no combinational path from out_ready to src_ack.
- Arbitration: combinational, fixed priority, highest index wins. This matches the sqrt-over-div tie rule.
- src_ack[i]=1 only when push_en, src_done[i], and no higher-index src_done is asserted. At most one ack bit is set per cycle.
- Ack semantics: the acked source's id/data are written into FIFO[wr_ptr] on the same clock edge. wr_ptr toggles.
- Pop: pop = out_valid & out_ready. rd_ptr toggles on pop.
- Simultaneous push and pop: count is unchanged. Both pointers advance.
- Full case (count==2): no ack is issued even if out_ready=1 in that cycle. Pop completes first, so the next push occurs one cycle later.
- Empty case: out_valid=0. out_ready is ignored and no pop occurs.
- Outputs are driven from the FIFO head registers: out_valid=(count!=0), out_id/out_data=FIFO[rd_ptr].
- Latency: src_done at cycle t with empty FIFO gives out_valid at cycle t+1.
- Throughput: one result per cycle sustained when out_ready is held at 1.
- Ordering: results leave in ack order.
- Source hold: a non-acked source must hold done/id/data stable. The arbiter does not latch non-granted inputs.
- Assertions (simulation only): src_ack is onehot0; count never exceeds 2; no pop while count==0.

Optional Feature:
- Macro: FP_WB_ARB_RR_EN.
- Defined: the fixed-priority arbiter is replaced by round-robin.
  - A registered last-grant index, reset to NUM_SOURCES-1, gives lowest priority to the most recently granted source.
  - The index updates only on an actual ack.
  - This prevents div/sqrt from starving madd during back-to-back sqrt streams.
- Undefined: fixed priority as specified above, and no last-grant register exists.

Test Plan:
- Reset, then src_done[0]=1 with id=1, data=0xA5 for one cycle, out_ready=1 → src_ack[0]=1 at t; out_valid=1, out_id=1, out_data=0xA5 at t+1; out_valid=0 at t+2.
- src_done[2] and src_done[0] asserted together with ids 2 and 0 → src_ack=3'b100 first, then 3'b001 next cycle. Outputs appear id 2 then id 0. With FP_WB_ARB_RR_EN, two consecutive ties alternate grants 2,0,2.
- out_ready=0, three sources each pulse done → two acks accepted and count=2. The third source waits with ack=0. Raise out_ready → head pops; the third source is acked one cycle after the pop.
- Steady state: count=1, src_done[1]=1 and out_ready=1 every cycle for 8 cycles → one ack per cycle, count stays 1, ids emerge in order.
- Assert rst asynchronously mid-cycle with count=2 → out_valid and src_ack drop immediately without waiting for a clock edge; after release, out_valid stays 0 until a new done.
